// File: rtl/selector_rr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : selector_rr_arbiter                                        |
// | Description : Round-robin arbiter sharing a 4-way 4-bit data selector    |
// |               between four requesters. Registered one-hot grant drives   |
// |               the selector code; each tenure is bounded to QUANTUM       |
// |               cycles. Optional macro ARB_LOCK_EN adds an i_lock input    |
// |               that suppresses quantum expiry for atomic transfers.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

module selector_rr_arbiter_mux4 (
  input  logic [1:0] i_sel,
  input  logic [3:0] i_c0,
  input  logic [3:0] i_c1,
  input  logic [3:0] i_c2,
  input  logic [3:0] i_c3,
  output logic [3:0] o_y
);

  // Plain 4:1 data selector indexed by the owner code.
  always_comb begin
    o_y = i_c0;
    case (i_sel)
      2'd0:    o_y = i_c0;
      2'd1:    o_y = i_c1;
      2'd2:    o_y = i_c2;
      default: o_y = i_c3;
    endcase
  end

endmodule

module selector_rr_arbiter #(
  parameter int QUANTUM = 4,
  parameter int CNT_W   = 3
) (
  input  logic       clk,
  input  logic       n_reset,
`ifdef ARB_LOCK_EN
  input  logic       i_lock,
`endif
  input  logic [3:0] i_req,
  input  logic [3:0] i_c0,
  input  logic [3:0] i_c1,
  input  logic [3:0] i_c2,
  input  logic [3:0] i_c3,
  output logic [3:0] o_gnt,
  output logic [1:0] o_sel,
  output logic [3:0] o_y,
  output logic       o_y_valid,
  output logic       o_busy
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(QUANTUM - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [3:0]       r_gnt;
  logic [3:0]       w_gnt_nxt;
  logic [1:0]       r_sel;
  logic [1:0]       w_sel_nxt;
  logic [1:0]       r_last;
  logic [1:0]       w_last_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_busy;
  logic             w_busy_nxt;

  logic             w_found;
  logic [1:0]       w_win;
  logic [1:0]       w_idx;
  logic             w_lock;
  logic             w_expire;
  logic             w_keep;

`ifdef ARB_LOCK_EN
  assign w_lock = i_lock;
`else
  assign w_lock = 1'b0;
`endif

  // In GRANT r_last equals the owner, so searching from r_last+1 also gives
  // the owner lowest priority at tenure end.
  assign w_expire = (r_cnt >= c_CNT_MAX);
  assign w_keep   = i_req[r_sel] && (!w_expire || w_lock);

  // Round-robin search: last+1, last+2, last+3, last; nearest set request wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    w_idx   = r_last;
    for (int k = 4; k >= 1; k--) begin
      w_idx = r_last + 2'(k);
      if (i_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Next-state and next-output logic; everything holds unless changed below.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_GRANT;
          w_gnt_nxt   = 4'b0001 << w_win;
          w_sel_nxt   = w_win;
          w_last_nxt  = w_win;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      S_GRANT: begin
        if (w_keep) begin
          // Saturates at the maximum while a lock holds the tenure open.
          if (!w_expire) begin
            w_cnt_nxt = r_cnt + c_CNT_ONE;
          end
        end else if (w_found) begin
          // Hand over on the same edge; may re-grant the owner if it is alone.
          w_gnt_nxt  = 4'b0001 << w_win;
          w_sel_nxt  = w_win;
          w_last_nxt = w_win;
          w_cnt_nxt  = '0;
        end else begin
          // Nobody left: drop the grant, keep sel at the previous owner.
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = 4'b0000;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = 4'b0000;
        w_cnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers; last=3 on reset so source 0 is served first.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= S_IDLE;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'd0;
      r_last  <= 2'd3;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  selector_rr_arbiter_mux4 u_mux (
    .i_sel (r_sel),
    .i_c0  (i_c0),
    .i_c1  (i_c1),
    .i_c2  (i_c2),
    .i_c3  (i_c3),
    .o_y   (o_y)
  );

  assign o_gnt     = r_gnt;
  assign o_sel     = r_sel;
  assign o_busy    = r_busy;
  assign o_y_valid = |r_gnt;

endmodule

`default_nettype wire

// File: tb/tb_selector_rr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_selector_rr_arbiter                                     |
// | Description : Self-checking bench for selector_rr_arbiter with a         |
// |               behavioural round-robin model feeding an expected-value    |
// |               queue, plus directed pattern checks.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_selector_rr_arbiter;

  localparam int QUANTUM = 4;
  localparam int CNT_W   = 3;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       vld;
    logic [3:0] y;
  } exp_t;

  logic       clk = 1'b0;
  logic       n_reset;
`ifdef ARB_LOCK_EN
  logic       i_lock;
`endif
  logic [3:0] i_req;
  logic [3:0] i_c0, i_c1, i_c2, i_c3;
  logic [3:0] o_gnt;
  logic [1:0] o_sel;
  logic [3:0] o_y;
  logic       o_y_valid;
  logic       o_busy;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // model state
  int m_own;
  int m_cnt;
  int m_last;
  int m_sel;

  selector_rr_arbiter #(.QUANTUM(QUANTUM), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
`ifdef ARB_LOCK_EN
    .i_lock    (i_lock),
`endif
    .i_req     (i_req),
    .i_c0      (i_c0),
    .i_c1      (i_c1),
    .i_c2      (i_c2),
    .i_c3      (i_c3),
    .o_gnt     (o_gnt),
    .o_sel     (o_sel),
    .o_y       (o_y),
    .o_y_valid (o_y_valid),
    .o_busy    (o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] cval(int s);
    case (s)
      0:       return i_c0;
      1:       return i_c1;
      2:       return i_c2;
      default: return i_c3;
    endcase
  endfunction

  function automatic exp_t dut_obs();
    exp_t o;
    o.gnt  = o_gnt;
    o.sel  = o_sel;
    o.busy = o_busy;
    o.vld  = o_y_valid;
    o.y    = o_y;
    return o;
  endfunction

  function automatic string fmt(exp_t e);
    return $sformatf("gnt=%b sel=%0d busy=%b vld=%b y=%h", e.gnt, e.sel, e.busy, e.vld, e.y);
  endfunction

  task automatic model_reset();
    m_own  = -1;
    m_cnt  = 0;
    m_last = 3;
    m_sel  = 0;
    q.delete();
  endtask

  // Advance the model with the inputs present before the edge, queue the
  // expected post-edge outputs, then wait for the edge and settle.
  task automatic edge_step();
    exp_t e;
    int   nxt;
    logic lk;
    lk = 1'b0;
`ifdef ARB_LOCK_EN
    lk = i_lock;
`endif
    if (m_own >= 0 && i_req[m_own] && (m_cnt < QUANTUM - 1 || lk)) begin
      if (m_cnt < QUANTUM - 1) m_cnt++;
    end else begin
      nxt = -1;
      for (int k = 1; k <= 4; k++)
        if (nxt < 0 && i_req[(m_last + k) % 4]) nxt = (m_last + k) % 4;
      if (nxt >= 0) begin
        m_own = nxt; m_last = nxt; m_sel = nxt; m_cnt = 0;
      end else begin
        m_own = -1; m_cnt = 0;
      end
    end
    e.gnt  = (m_own < 0) ? 4'b0000 : (4'b0001 << m_own);
    e.sel  = 2'(m_sel);
    e.busy = (m_own >= 0);
    e.vld  = (m_own >= 0);
    e.y    = cval(m_sel);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    i_req   = 4'b0000;
`ifdef ARB_LOCK_EN
    i_lock  = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    exp_t e;
    n_reset = 1'b0;
    i_req   = 4'b1111;
    #12;
    n_total++;
    if ({o_gnt, o_sel, o_busy, o_y_valid} !== 8'b0) begin
      $display("FAIL reset_initial: got gnt=%b sel=%0d busy=%b vld=%b, required all zero",
               o_gnt, o_sel, o_busy, o_y_valid);
    end else n_pass++;
    do_reset();
    i_req = 4'b0100;
    edge_step();
    e = q.pop_front();
    n_total++;
    if (dut_obs() !== e || o_gnt !== 4'b0100) begin
      $display("FAIL reset_pre_grant: got %s, required %s", fmt(dut_obs()), fmt(e));
    end else n_pass++;
    // asynchronous assertion between edges
    #2;
    n_reset = 1'b0;
    #1;
    n_total++;
    if ({o_gnt, o_sel, o_busy, o_y_valid} !== 8'b0) begin
      $display("FAIL reset_async: got gnt=%b sel=%0d busy=%b vld=%b, required all zero",
               o_gnt, o_sel, o_busy, o_y_valid);
    end else n_pass++;
    @(negedge clk);
    n_reset = 1'b1;
    model_reset();
    i_req = 4'b1111;
    edge_step();
    e = q.pop_front();
    n_total++;
    if (dut_obs() !== e || o_gnt !== 4'b0001) begin
      $display("FAIL reset_restart_at_0: got %s, required %s", fmt(dut_obs()), fmt(e));
    end else n_pass++;
  endtask

  task automatic test_rotation();
    exp_t e;
    do_reset();
    i_req = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      edge_step();
      e = q.pop_front();
      n_total++;
      if (dut_obs() !== e) begin
        $display("FAIL rotation_model[%0d]: got %s, required %s", i, fmt(dut_obs()), fmt(e));
      end else n_pass++;
      n_total++;
      if (o_gnt !== (4'b0001 << ((i / 4) % 4)) || o_sel !== 2'((i / 4) % 4)) begin
        $display("FAIL rotation_pattern[%0d]: got gnt=%b sel=%0d, required gnt=%b sel=%0d",
                 i, o_gnt, o_sel, 4'b0001 << ((i / 4) % 4), (i / 4) % 4);
      end else n_pass++;
    end
  endtask

  task automatic test_single();
    exp_t e;
    do_reset();
    i_req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      edge_step();
      e = q.pop_front();
      n_total++;
      if (dut_obs() !== e || o_gnt !== 4'b0001 || o_busy !== 1'b1) begin
        $display("FAIL single_owner[%0d]: got %s, required %s", i, fmt(dut_obs()), fmt(e));
      end else n_pass++;
    end
  endtask

  task automatic test_drop();
    exp_t e;
    logic [3:0] req_seq [5];
    logic [3:0] gnt_seq [5];
    req_seq = '{4'b0100, 4'b0100, 4'b0001, 4'b0000, 4'b0000};
    gnt_seq = '{4'b0100, 4'b0100, 4'b0001, 4'b0000, 4'b0000};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      i_req = req_seq[i];
      edge_step();
      e = q.pop_front();
      n_total++;
      if (dut_obs() !== e || o_gnt !== gnt_seq[i]) begin
        $display("FAIL drop[%0d]: got %s, required %s (gnt %b)", i, fmt(dut_obs()), fmt(e), gnt_seq[i]);
      end else n_pass++;
    end
    n_total++;
    if (o_sel !== 2'd0 || o_y_valid !== 1'b0 || o_busy !== 1'b0) begin
      $display("FAIL drop_idle_hold: got sel=%0d vld=%b busy=%b, required sel=0 vld=0 busy=0",
               o_sel, o_y_valid, o_busy);
    end else n_pass++;
  endtask

  task automatic test_data();
    exp_t e;
    logic [3:0] dv [4];
    dv = '{4'h3, 4'hA, 4'h5, 4'hF};
    i_c0 = 4'h3; i_c1 = 4'hA; i_c2 = 4'h5; i_c3 = 4'hF;
    do_reset();
    i_req = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      edge_step();
      e = q.pop_front();
      n_total++;
      if (dut_obs() !== e) begin
        $display("FAIL data_model[%0d]: got %s, required %s", i, fmt(dut_obs()), fmt(e));
      end else n_pass++;
      n_total++;
      if (o_y !== dv[(i / 4) % 4] || o_y_valid !== 1'b1) begin
        $display("FAIL data_y[%0d]: got y=%h vld=%b, required y=%h vld=1",
                 i, o_y, o_y_valid, dv[(i / 4) % 4]);
      end else n_pass++;
    end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    exp_t e;
    do_reset();
    i_lock = 1'b1;
    i_req  = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      edge_step();
      e = q.pop_front();
      n_total++;
      if (dut_obs() !== e || o_gnt !== 4'b0001) begin
        $display("FAIL lock_hold[%0d]: got %s, required %s", i, fmt(dut_obs()), fmt(e));
      end else n_pass++;
    end
    i_lock = 1'b0;
    edge_step();
    e = q.pop_front();
    n_total++;
    if (dut_obs() !== e || o_gnt !== 4'b0010) begin
      $display("FAIL lock_release: got %s, required %s", fmt(dut_obs()), fmt(e));
    end else n_pass++;
  endtask
`endif

  initial begin
    n_reset = 1'b0;
    i_req   = 4'b0000;
`ifdef ARB_LOCK_EN
    i_lock  = 1'b0;
`endif
    i_c0 = 4'h9; i_c1 = 4'h6; i_c2 = 4'hC; i_c3 = 4'h0;
    model_reset();
    test_reset();
    test_rotation();
    test_single();
    test_drop();
    test_data();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
